// File: rtl/sample_reader_pkg.sv
// Shared types and constants for the dual-channel IIR sample reader.
package sample_reader_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND_A = 2'd1,
    SEND_B = 2'd2
  } reader_state_t;

  localparam logic [15:0] OVERRUN_MAX = 16'hFFFF;

endpackage

// File: rtl/sample_pair_fifo.sv
// Synchronous FIFO of {first, second} word pairs; exposes the head pair and the
// first word of the entry behind it so a reader can stream pairs without a bubble.
module sample_pair_fifo #(
  parameter int WORD_BITS  = 32,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WORD_BITS-1:0]  push_first,
  input  logic [WORD_BITS-1:0]  push_second,
  output logic [WORD_BITS-1:0]  head_first,
  output logic [WORD_BITS-1:0]  head_second,
  output logic [WORD_BITS-1:0]  next_first,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [2*WORD_BITS-1:0] mem [DEPTH];
  logic [DEPTH_LOG2:0]    wr_ptr;
  logic [DEPTH_LOG2:0]    rd_ptr;
  logic [DEPTH_LOG2-1:0]  wr_addr;
  logic [DEPTH_LOG2-1:0]  rd_addr;
  logic [DEPTH_LOG2-1:0]  rd_addr_next;
  logic                   push_ok;
  logic                   pop_ok;

  assign wr_addr      = wr_ptr[DEPTH_LOG2-1:0];
  assign rd_addr      = rd_ptr[DEPTH_LOG2-1:0];
  assign rd_addr_next = rd_addr + DEPTH_LOG2'(1);

  assign count = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) && (wr_addr == rd_addr);

  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;

  assign head_first  = mem[rd_addr][2*WORD_BITS-1:WORD_BITS];
  assign head_second = mem[rd_addr][WORD_BITS-1:0];
  assign next_first  = mem[rd_addr_next][2*WORD_BITS-1:WORD_BITS];

  always_ff @(posedge CLK) begin
    if (push_ok) begin
      mem[wr_addr] <= {push_first, push_second};
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + (DEPTH_LOG2+1)'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + (DEPTH_LOG2+1)'(1);
    end
  end

endmodule

// File: rtl/iir_dblchannel_sample_reader.sv
// Periodic atomic A/B snapshot of the filter outputs, buffered and streamed as
// A-then-B words on a valid/ready port; overruns are counted, never stalled.
module iir_dblchannel_sample_reader
  import sample_reader_pkg::*;
#(
  parameter int DATA_BITS       = 32,
  parameter int FIFO_DEPTH_LOG2 = 2,
  parameter int DIV_BITS        = 16
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [DATA_BITS-1:0] IN_VALUE_A,
  input  logic [DATA_BITS-1:0] IN_VALUE_B,
  input  logic                 ENABLE,
  input  logic [DIV_BITS-1:0]  SAMPLE_DIV,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic [DATA_BITS-1:0] OUT_DATA,
  output logic                 OUT_LAST,
  output logic [15:0]          OVERRUN_COUNT,
  input  logic                 CLEAR_OVERRUN
);

  localparam logic [FIFO_DEPTH_LOG2:0] CNT_ONE = (FIFO_DEPTH_LOG2+1)'(1);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == OVERRUN_MAX) ? v : v + 16'd1;
  endfunction

  logic [DIV_BITS-1:0]        div_cnt;
  logic                       tick_p0;
  logic                       pop;
  logic                       drop;
  logic                       more_after_pop;
  logic [DATA_BITS-1:0]       head_a;
  logic [DATA_BITS-1:0]       head_b;
  logic [DATA_BITS-1:0]       next_a;
  logic [DATA_BITS-1:0]       follow_a;
  logic [FIFO_DEPTH_LOG2:0]   fifo_count;
  logic                       fifo_full;
  logic                       fifo_empty;
  reader_state_t              state;
  reader_state_t              state_nxt;
  logic                       valid_nxt;
  logic                       last_nxt;
  logic [DATA_BITS-1:0]       data_nxt;

  // Stage p0: sample-period divider; counter >= SAMPLE_DIV also covers a lowered divisor.
  assign tick_p0 = ENABLE && (div_cnt >= SAMPLE_DIV);

  always_ff @(posedge CLK) begin
    if (RESET || !ENABLE || tick_p0) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_BITS'(1);
    end
  end

  // Stage p1: pair buffer; both channels are written from the tick cycle in one entry.
  sample_pair_fifo #(
    .WORD_BITS  (DATA_BITS),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .CLK         (CLK),
    .RESET       (RESET),
    .push        (tick_p0),
    .pop         (pop),
    .push_first  (IN_VALUE_A),
    .push_second (IN_VALUE_B),
    .head_first  (head_a),
    .head_second (head_b),
    .next_first  (next_a),
    .count       (fifo_count),
    .full        (fifo_full),
    .empty       (fifo_empty)
  );

  assign pop  = (state == SEND_B) && OUT_READY;
  assign drop = tick_p0 && fifo_full && !pop;

  // A same-cycle push always lands when popping, so it can become the next head.
  assign more_after_pop = (fifo_count > CNT_ONE) || tick_p0;
  assign follow_a       = (fifo_count > CNT_ONE) ? next_a : IN_VALUE_A;

  always_ff @(posedge CLK) begin
    if (RESET || CLEAR_OVERRUN) begin
      OVERRUN_COUNT <= '0;
    end else if (drop) begin
      OVERRUN_COUNT <= sat_inc(OVERRUN_COUNT);
    end
  end

  // Stage p2: word sequencer and registered output port.
  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (!fifo_empty) state_nxt = SEND_A;
      SEND_A:  if (OUT_READY)   state_nxt = SEND_B;
      SEND_B:  if (OUT_READY)   state_nxt = more_after_pop ? SEND_A : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    valid_nxt = OUT_VALID;
    last_nxt  = OUT_LAST;
    data_nxt  = OUT_DATA;
    unique case (state)
      IDLE: begin
        if (!fifo_empty) begin
          valid_nxt = 1'b1;
          last_nxt  = 1'b0;
          data_nxt  = head_a;
        end
      end
      SEND_A: begin
        if (OUT_READY) begin
          last_nxt = 1'b1;
          data_nxt = head_b;
        end
      end
      SEND_B: begin
        if (OUT_READY) begin
          if (more_after_pop) begin
            last_nxt = 1'b0;
            data_nxt = follow_a;
          end else begin
            valid_nxt = 1'b0;
          end
        end
      end
      default: valid_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      OUT_VALID <= 1'b0;
      OUT_LAST  <= 1'b0;
      OUT_DATA  <= '0;
    end else begin
      OUT_VALID <= valid_nxt;
      OUT_LAST  <= last_nxt;
      OUT_DATA  <= data_nxt;
    end
  end

endmodule
